// File: rtl/bp_pkg.sv
// Shared types for the branch predictor: 2-bit counter encodings, queue entry
// layout and the saturating counter update.
package bp_pkg;

  localparam int BP_ADDRESS_WIDTH = 32;
  localparam int BP_INDEX_BITS    = 6;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } counter_t;

  localparam counter_t COUNTER_RESET = WNT;

  // Queue entry field widths follow BP_ADDRESS_WIDTH / BP_INDEX_BITS.
  typedef struct packed {
    logic [BP_INDEX_BITS-1:0]    index;
    logic                        pred_taken;
    logic [BP_ADDRESS_WIDTH-1:0] pred_pc;
    logic [BP_ADDRESS_WIDTH-1:0] fallthrough_pc;
  } bp_entry_t;

  function automatic counter_t sat_update(input counter_t ctr, input logic taken);
    counter_t nxt;
    nxt = ctr;
    case (ctr)
      SNT:     nxt = taken ? WNT : SNT;
      WNT:     nxt = taken ? WT  : SNT;
      WT:      nxt = taken ? ST  : WNT;
      ST:      nxt = taken ? ST  : WT;
      default: nxt = ctr;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Lookup / prediction / resolve / redirect bundle between fetch, execute and
// the branch predictor.
interface branch_predictor_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int QUEUE_DEPTH   = 4
);
  localparam int COUNT_W = $clog2(QUEUE_DEPTH) + 1;

  logic                     i_Stall;
  logic                     i_isbranch;
  logic [ADDRESS_WIDTH-1:0] i_branch_address;
  logic [ADDRESS_WIDTH-1:0] i_Branch_Target;
  logic                     o_lookup_ready;
  logic                     o_predict_valid;
  logic                     o_predict_taken;
  logic [ADDRESS_WIDTH-1:0] o_Predicted_PC;
  logic                     i_resolve_valid;
  logic                     i_resolve_taken;
  logic [ADDRESS_WIDTH-1:0] i_resolve_target;
  logic                     o_mispredict;
  logic [ADDRESS_WIDTH-1:0] o_Redirect_PC;
  logic [COUNT_W-1:0]       o_queue_count;

  modport master (
    output i_Stall, i_isbranch, i_branch_address, i_Branch_Target,
           i_resolve_valid, i_resolve_taken, i_resolve_target,
    input  o_lookup_ready, o_predict_valid, o_predict_taken, o_Predicted_PC,
           o_mispredict, o_Redirect_PC, o_queue_count
  );

  modport slave (
    input  i_Stall, i_isbranch, i_branch_address, i_Branch_Target,
           i_resolve_valid, i_resolve_taken, i_resolve_target,
    output o_lookup_ready, o_predict_valid, o_predict_taken, o_Predicted_PC,
           o_mispredict, o_Redirect_PC, o_queue_count
  );

endinterface

// File: rtl/bp_resolve_queue.sv
// In-order FIFO of outstanding predictions awaiting execute-stage resolution.
// Flush empties the queue and wins over a same-cycle push.
module bp_resolve_queue
  import bp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  bp_entry_t              push_entry,
  output bp_entry_t              head,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  bp_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_CNT);
  assign do_push = push && !flush && !full;
  assign do_pop  = pop && !flush && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/branch_predictor.sv
// 2-bit saturating-counter branch predictor with an in-order resolve queue,
// counter training on resolve, and mispredict redirect with queue flush.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ADDRESS_WIDTH = BP_ADDRESS_WIDTH,
  parameter int INDEX_BITS    = BP_INDEX_BITS,
  parameter int QUEUE_DEPTH   = 4
) (
  input logic               i_Clk,
  input logic               i_Reset_n,
  branch_predictor_if.slave bus
);

  localparam int ENTRIES = 2 ** INDEX_BITS;
  localparam int COUNT_W = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [COUNT_W-1:0] DEPTH_CNT = COUNT_W'(QUEUE_DEPTH);

  counter_t                 ctr_table [ENTRIES];
  bp_entry_t                head;
  bp_entry_t                push_entry;
  logic                     q_empty;
  logic [COUNT_W-1:0]       q_count;

  logic                     ready_en_q;
  logic                     lookup_ready;
  logic                     resolve_fire;
  logic                     mispredict_now;
  logic                     lookup_fire;
  logic [ADDRESS_WIDTH-1:0] actual_pc;
  logic [ADDRESS_WIDTH-1:0] fallthrough_pc;
  logic [ADDRESS_WIDTH-1:0] lookup_pc;
  logic [INDEX_BITS-1:0]    lookup_index;
  counter_t                 trained_ctr;
  counter_t                 lookup_ctr;
  logic                     lookup_taken;

  logic                     predict_valid_p1;
  logic                     predict_taken_p1;
  logic [ADDRESS_WIDTH-1:0] predicted_pc_p1;
  logic                     mispredict_p1;
  logic [ADDRESS_WIDTH-1:0] redirect_pc_p1;

  // Ready comes from the registered count only, held low until the first
  // clock after reset release.
  assign lookup_ready = ready_en_q && (q_count < DEPTH_CNT);

  always_comb begin
    resolve_fire   = bus.i_resolve_valid && !q_empty;
    actual_pc      = bus.i_resolve_taken ? bus.i_resolve_target : head.fallthrough_pc;
    // For a not-taken prediction the stored pred_pc equals fallthrough_pc.
    mispredict_now = resolve_fire &&
                     (head.pred_taken ? (actual_pc != head.pred_pc)
                                      : (actual_pc != head.fallthrough_pc));
    trained_ctr    = sat_update(ctr_table[head.index], bus.i_resolve_taken);

    lookup_index   = bus.i_branch_address[INDEX_BITS-1:0];
    // Same-index training in this cycle is forwarded to the lookup.
    lookup_ctr     = (resolve_fire && (head.index == lookup_index)) ? trained_ctr
                                                                    : ctr_table[lookup_index];
    lookup_taken   = (lookup_ctr == WT) || (lookup_ctr == ST);
    fallthrough_pc = bus.i_branch_address + 1'b1;
    lookup_pc      = lookup_taken ? bus.i_Branch_Target : fallthrough_pc;
    lookup_fire    = bus.i_isbranch && !bus.i_Stall && lookup_ready && !mispredict_now;

    push_entry     = '{index:          lookup_index,
                       pred_taken:     lookup_taken,
                       pred_pc:        lookup_pc,
                       fallthrough_pc: fallthrough_pc};
  end

  bp_resolve_queue #(
    .DEPTH(QUEUE_DEPTH)
  ) u_queue (
    .clk       (i_Clk),
    .rst_n     (i_Reset_n),
    .push      (lookup_fire),
    .pop       (resolve_fire),
    .flush     (mispredict_now),
    .push_entry(push_entry),
    .head      (head),
    .empty     (q_empty),
    .count     (q_count)
  );

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      for (int i = 0; i < ENTRIES; i++) ctr_table[i] <= COUNTER_RESET;
    end else if (resolve_fire) begin
      ctr_table[head.index] <= trained_ctr;
    end
  end

  // Stage p1: registered prediction and redirect outputs
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      ready_en_q       <= 1'b0;
      predict_valid_p1 <= 1'b0;
      predict_taken_p1 <= 1'b0;
      predicted_pc_p1  <= '0;
      mispredict_p1    <= 1'b0;
      redirect_pc_p1   <= '0;
    end else begin
      ready_en_q       <= 1'b1;
      predict_valid_p1 <= lookup_fire;
      if (lookup_fire) begin
        predict_taken_p1 <= lookup_taken;
        predicted_pc_p1  <= lookup_pc;
      end
      mispredict_p1 <= mispredict_now;
      if (mispredict_now) redirect_pc_p1 <= actual_pc;
    end
  end

  assign bus.o_lookup_ready  = lookup_ready;
  assign bus.o_predict_valid = predict_valid_p1;
  assign bus.o_predict_taken = predict_taken_p1;
  assign bus.o_Predicted_PC  = predicted_pc_p1;
  assign bus.o_mispredict    = mispredict_p1;
  assign bus.o_Redirect_PC   = redirect_pc_p1;
  assign bus.o_queue_count   = q_count;

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Consumes branch-detect outputs of the fetch-group pre-aligner (branch flag, branch PC, decoded target).
- Returns a registered taken/not-taken prediction and predicted next PC to fetch.
- Prediction uses a direct-mapped table of 2-bit saturating counters.
- Holds outstanding predictions in an in-order queue, matches each against the execute-stage resolve, trains the counter, and signals mispredict redirect.

Parameters:
ADDRESS_WIDTH, 32, PC width (word-addressed; next sequential PC = PC+1)
INDEX_BITS, 6, counter table has 2^INDEX_BITS entries, index = PC[INDEX_BITS-1:0]
QUEUE_DEPTH, 4, outstanding-prediction queue entries (power of 2, >=2)

Ports:
i_Clk  in  1  clock; all state on rising edge
i_Reset_n  in  1  asynchronous active-low reset
i_Stall  in  1  blocks lookup acceptance only
i_isbranch  in  1  lookup request
i_branch_address  in  ADDRESS_WIDTH  PC of branch
i_Branch_Target  in  ADDRESS_WIDTH  decoded taken target
o_lookup_ready  out  1  queue not full (count < QUEUE_DEPTH)
o_predict_valid  out  1  one-cycle pulse, prediction available
o_predict_taken  out  1  predicted direction
o_Predicted_PC  out  ADDRESS_WIDTH  target if taken, else branch_address+1
i_resolve_valid  in  1  execute resolved oldest outstanding branch
i_resolve_taken  in  1  actual direction
i_resolve_target  in  ADDRESS_WIDTH  actual taken target
o_mispredict  out  1  one-cycle pulse, fetch must redirect
o_Redirect_PC  out  ADDRESS_WIDTH  correct next PC
o_queue_count  out  clog2(QUEUE_DEPTH)+1  outstanding predictions

Behaviour:
- Reset (async, immediate):
  - All outputs 0; o_lookup_ready becomes 1 at first clock after release.
  - Queue empty; every counter set to weakly-not-taken (01).
  - Reset mid-operation discards all in-flight state.
- Lookup:
  - Accepted when i_isbranch && !i_Stall && o_lookup_ready && !mispredict_now.
  - Counter read at index; taken = counter[1].
  - Next cycle: o_predict_valid=1 with o_predict_taken, o_Predicted_PC. Latency 1, pulse lasts 1 cycle.
  - Outputs hold last values while o_predict_valid=0.
  - Entry {index, taken, predicted PC, fallthrough = PC+1} pushed to queue tail.
  - PC+1 wraps modulo 2^ADDRESS_WIDTH.
- Resolve:
  - Processed only if queue non-empty, regardless of i_Stall. On empty queue: ignored, no training, no pulse.
  - Head popped; actual = i_resolve_taken ? i_resolve_target : fallthrough.
  - mispredict_now = (actual != head predicted PC), combinational in resolve cycle.
  - Next cycle: o_mispredict=1, o_Redirect_PC=actual.
  - Counter at head index trained on every resolve: taken increments (saturate 11), not-taken decrements (saturate 00).
- Flush:
  - On mispredict_now the entire queue is cleared at that edge; count becomes 0.
  - A lookup presented the same cycle is dropped: not enqueued, no o_predict_valid.
- Full:
  - o_lookup_ready derives from registered count only.
  - When full, lookup is refused even if a pop occurs the same cycle.
- Simultaneous events:
  - Correct resolve + accepted lookup at same index: lookup sees post-update counter (bypass).
  - Push + pop in same cycle: count unchanged.
- Aliasing: PCs sharing the low INDEX_BITS share a counter, by design.
- Counter table is plain flops with async reset (no RAM).

Decomposition:
- Package bp_pkg:
  - Counter encodings SNT=00, WNT=01, WT=10, ST=11; COUNTER_RESET=WNT.
  - Queue entry struct {index, pred_taken, pred_pc, fallthrough_pc}.
  - Saturating-update function.
- One sub-module bp_resolve_queue:
  - Parameterized FIFO with push, pop, flush, count; flush has priority over push.

Test Plan:
- Reset, lookup PC 0x10 target 0x40 → next cycle valid=1, taken=0, Predicted_PC 0x11; count=1.
- Resolve taken target 0x40 → next cycle mispredict=1, Redirect_PC 0x40, count 0; relookup 0x10 → taken=1, Predicted_PC 0x40.
- Four lookups without resolve → ready=0 and count=4; fifth ignored; one correct resolve → count 3, ready=1 next cycle.
- Train index 0x10 taken x4 → counter stays 11; one not-taken → 10, still predicts taken; two more not-taken → predicts not-taken, Predicted_PC 0x11.
- Three outstanding, mispredicting resolve plus same-cycle lookup 0x20 → count 0, no predict_valid; resolve on empty queue → no pulse, counters unchanged.
- Train 0x10 to taken, look up 0x50 (alias) → taken; assert i_Reset_n=0 mid-queue → outputs 0 immediately, post-reset lookup 0x10 → not-taken.
